// File: rtl/u_xmit_fifo_if.sv
// ---------------------------------------------------------------------------
// u_xmit_fifo_if
//   Bundles the host push side and the transmitter hand-off side of the
//   byte transmit FIFO so the FIFO and its neighbours share one port.
//
//   Signals
//     wr_enH / wr_dataH   host push strobe and byte
//     fullH / emptyH      occupancy flags
//     countH              occupancy 0..DEPTH
//     xmitH / xmit_dataH  one-cycle start strobe and byte for u_xmit
//     xmit_doneH          transmitter idle/done, high while idle
//     ovf_clrH            clear for the sticky overflow flag
//     overflowH           sticky overflow flag
//
//   Modports
//     master  host + transmitter side (drives pushes and xmit_doneH)
//     slave   the FIFO itself
// ---------------------------------------------------------------------------
interface u_xmit_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  wr_enH;
  logic [7:0]            wr_dataH;
  logic                  fullH;
  logic                  emptyH;
  logic [DEPTH_LOG2:0]   countH;
  logic                  xmitH;
  logic [7:0]            xmit_dataH;
  logic                  xmit_doneH;
  logic                  ovf_clrH;
  logic                  overflowH;

  modport master (
    output wr_enH, wr_dataH, xmit_doneH, ovf_clrH,
    input  fullH, emptyH, countH, xmitH, xmit_dataH, overflowH
  );

  modport slave (
    input  wr_enH, wr_dataH, xmit_doneH, ovf_clrH,
    output fullH, emptyH, countH, xmitH, xmit_dataH, overflowH
  );
endinterface

// File: rtl/u_xmit_fifo.sv
// ---------------------------------------------------------------------------
// u_xmit_fifo
//   Byte transmit buffer in front of the UART transmitter (u_xmit). The host
//   pushes bytes with a single-cycle strobe; a feeder FSM pops one byte at a
//   time, pulses xmitH for one cycle and then waits for the transmitter to
//   accept (xmit_doneH low) and finish (xmit_doneH high) before the next pop.
//
//   Ports
//     sys_clk     system clock, rising edge
//     sys_rst_l   asynchronous active-low reset
//     bus         u_xmit_fifo_if.slave (push side, flags, transmitter side)
//
//   Parameters
//     DEPTH_LOG2  log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 bytes)
//
//   Configuration macro
//     XMIT_FIFO_OVF_EN  when defined, overflowH is a sticky flag set by any
//                       push into a full FIFO and cleared by ovf_clrH (set
//                       wins). When undefined, overflowH is 0 and drops are
//                       silent.
// ---------------------------------------------------------------------------
module u_xmit_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic            sys_clk,
  input  logic            sys_rst_l,
  u_xmit_fifo_if.slave    bus
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   C_FULL    = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   C_CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_ISSUE = 2'd1,
    F_BUSY  = 2'd2,
    F_WAIT  = 2'd3
  } state_t;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wrPtr;
  logic [DEPTH_LOG2-1:0] r_rdPtr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_empty;
  logic                  r_full;
  state_t                r_state;
  logic                  r_xmit;
  logic [7:0]            r_xmitData;

  logic                  w_push;
  logic                  w_pop;
  logic [DEPTH_LOG2:0]   w_countNext;

  // A push into a full FIFO is dropped outright, even when a pop frees a
  // slot on the same edge; the flags are registered so full is what counts.
  assign w_push = bus.wr_enH && !r_full;
  assign w_pop  = (r_state == F_IDLE) && !r_empty && bus.xmit_doneH;

  always_comb begin
    w_countNext = r_count;
    case ({w_push, w_pop})
      2'b10:   w_countNext = r_count + C_CNT_ONE;
      2'b01:   w_countNext = r_count - C_CNT_ONE;
      default: w_countNext = r_count;
    endcase
  end

  // Storage has no reset; discarding contents is done by clearing pointers.
  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wrPtr] <= bus.wr_dataH;
  end

  // Pointers and occupancy; flags come from the same next-count value so
  // they can never disagree with countH.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + C_PTR_ONE;
      if (w_pop)  r_rdPtr <= r_rdPtr + C_PTR_ONE;
      r_count <= w_countNext;
      r_empty <= (w_countNext == '0);
      r_full  <= (w_countNext == C_FULL);
    end
  end

  // Feeder FSM. xmitH is registered and high only while in F_ISSUE; the
  // presented byte changes only on a pop so it is stable for the frame.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      r_state    <= F_IDLE;
      r_xmit     <= 1'b0;
      r_xmitData <= 8'h00;
    end else begin
      case (r_state)
        F_IDLE: begin
          if (w_pop) begin
            r_xmitData <= r_mem[r_rdPtr];
            r_xmit     <= 1'b1;
            r_state    <= F_ISSUE;
          end
        end
        F_ISSUE: begin
          r_xmit  <= 1'b0;
          r_state <= F_BUSY;
        end
        F_BUSY: begin
          if (!bus.xmit_doneH) r_state <= F_WAIT;
        end
        F_WAIT: begin
          if (bus.xmit_doneH) r_state <= F_IDLE;
        end
        default: begin
          r_xmit  <= 1'b0;
          r_state <= F_IDLE;
        end
      endcase
    end
  end

`ifdef XMIT_FIFO_OVF_EN
  logic r_overflow;

  // Sticky drop indicator; a new drop on the clearing cycle keeps it set.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      r_overflow <= 1'b0;
    end else if (bus.wr_enH && r_full) begin
      r_overflow <= 1'b1;
    end else if (bus.ovf_clrH) begin
      r_overflow <= 1'b0;
    end
  end

  assign bus.overflowH = r_overflow;
`else
  logic w_unused_ovfClr;
  assign w_unused_ovfClr = bus.ovf_clrH;
  assign bus.overflowH   = 1'b0;
`endif

  assign bus.countH     = r_count;
  assign bus.emptyH     = r_empty;
  assign bus.fullH      = r_full;
  assign bus.xmitH      = r_xmit;
  assign bus.xmit_dataH = r_xmitData;

endmodule

// File: tb/tb_u_xmit_fifo.sv
// ---------------------------------------------------------------------------
// tb_u_xmit_fifo
//   Self-checking bench for u_xmit_fifo. A small u_xmit model answers each
//   xmitH pulse with a fixed-length busy frame; a monitor collects the bytes
//   handed to the transmitter. Inputs change 1 time unit after the falling
//   edge and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_u_xmit_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;
  localparam int FRAME      = 6;
`ifdef XMIT_FIFO_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       done;
    logic [4:0] eCount;
    logic       eEmpty;
    logic       eFull;
    logic       eXmit;
    logic [7:0] eData;
  } vec_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_l = 1'b0;

  logic modelEn    = 1'b0;
  logic modelDone  = 1'b1;
  logic manualDone = 1'b1;
  int   modelCnt   = 0;

  int   tests = 0;
  int   fails = 0;
  int   peak  = 0;
  int   pulseCnt = 0;
  logic [7:0] rxQ[$];
  logic [7:0] lastData = 8'h00;
  logic       prevXmit = 1'b0;
  logic       prevRst  = 1'b0;

  vec_t vecs[9];

  u_xmit_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  u_xmit_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_l (sys_rst_l),
    .bus       (bus)
  );

  assign bus.xmit_doneH = modelEn ? modelDone : manualDone;

  always #5 sys_clk = ~sys_clk;

  task automatic checkVal(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter model: drops done when it sees xmitH, raises it FRAME
  // cycles later, like u_xmit finishing its stop bit.
  always @(negedge sys_clk) begin
    #1;
    if (!sys_rst_l) begin
      modelDone = 1'b1;
      modelCnt  = 0;
    end else if (bus.xmitH) begin
      modelDone = 1'b0;
      modelCnt  = FRAME;
    end else if (modelCnt > 0) begin
      modelCnt--;
      if (modelCnt == 0) modelDone = 1'b1;
    end
  end

  // Monitor: collects issued bytes, checks single-cycle pulses, that a pulse
  // only follows done high, and that the presented byte holds between pops.
  always @(negedge sys_clk) begin
    if (sys_rst_l && prevRst) begin
      if (bus.xmitH) begin
        checkVal("pulseWidth", prevXmit, 0);
        checkVal("pulseAfterDone", bus.xmit_doneH, 1);
        rxQ.push_back(bus.xmit_dataH);
        pulseCnt++;
      end else begin
        checkVal("dataStable", bus.xmit_dataH, lastData);
      end
    end
    lastData = bus.xmit_dataH;
    prevXmit = bus.xmitH;
    prevRst  = sys_rst_l;
  end

  task automatic applyStimulus(input logic wr, input logic [7:0] data);
    bus.wr_enH   = wr;
    bus.wr_dataH = data;
    @(negedge sys_clk);
    if (int'(bus.countH) > peak) peak = int'(bus.countH);
    #1;
    bus.wr_enH   = 1'b0;
  endtask

  task automatic pushByte(input logic [7:0] data);
    applyStimulus(1'b1, data);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      #1;
    end
  endtask

  task automatic doReset();
    sys_rst_l = 1'b0;
    repeat (2) @(negedge sys_clk);
    #1;
    sys_rst_l = 1'b1;
    idle(1);
  endtask

  task automatic waitRx(input string name, input int n, input int budget);
    int k = 0;
    while (rxQ.size() < n && k < budget) begin
      @(negedge sys_clk);
      #1;
      k++;
    end
    checkVal(name, rxQ.size(), n);
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [7:0] exp);
    checkVal(name, (idx < rxQ.size()) ? int'(rxQ[idx]) : -1, exp);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 8'hA5};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[4] = '{1'b1, 8'h3C, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 8'h3C};
    vecs[7] = '{1'b1, 8'h77, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h3C};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h3C};

    bus.wr_enH   = 1'b0;
    bus.wr_dataH = 8'h00;
    bus.ovf_clrH = 1'b0;

    // Reset values
    @(negedge sys_clk);
    checkVal("rstCount", bus.countH, 0);
    checkVal("rstEmpty", bus.emptyH, 1);
    checkVal("rstFull", bus.fullH, 0);
    checkVal("rstXmit", bus.xmitH, 0);
    checkVal("rstData", bus.xmit_dataH, 8'h00);
    checkVal("rstOvf", bus.overflowH, 0);
    #1;
    doReset();

    // Cycle-by-cycle vectors: single push, issue latency, FSM handshake
    for (int i = 0; i < 9; i++) begin
      bus.wr_enH   = vecs[i].wr;
      bus.wr_dataH = vecs[i].data;
      manualDone   = vecs[i].done;
      @(negedge sys_clk);
      checkVal($sformatf("v%0d.count", i), bus.countH, vecs[i].eCount);
      checkVal($sformatf("v%0d.empty", i), bus.emptyH, vecs[i].eEmpty);
      checkVal($sformatf("v%0d.full", i), bus.fullH, vecs[i].eFull);
      checkVal($sformatf("v%0d.xmit", i), bus.xmitH, vecs[i].eXmit);
      checkVal($sformatf("v%0d.data", i), bus.xmit_dataH, vecs[i].eData);
      #1;
    end
    bus.wr_enH = 1'b0;

    // Three back-to-back pushes drained through the transmitter model
    manualDone = 1'b1;
    modelEn    = 1'b1;
    doReset();
    rxQ.delete();
    peak = 0;
    pushByte(8'h01);
    pushByte(8'h02);
    pushByte(8'h03);
    checkVal("b2bPeak", (peak == 2 || peak == 3), 1);
    waitRx("b2bRx", 3, 200);
    idle(3 * FRAME);
    checkVal("b2bPulses", rxQ.size(), 3);
    for (int i = 0; i < 3; i++) checkOutput("b2bOrder", i, 8'(i + 1));
    checkVal("b2bDrained", bus.countH, 0);

    // Overflow: transmitter held busy, DEPTH+1 pushes
    modelEn    = 1'b0;
    manualDone = 1'b0;
    doReset();
    rxQ.delete();
    for (int i = 0; i <= DEPTH; i++) pushByte(8'(8'h10 + i));
    checkVal("ovfFull", bus.fullH, 1);
    checkVal("ovfCount", bus.countH, 16);
    checkVal("ovfFlag", bus.overflowH, EXP_OVF);
    bus.ovf_clrH = 1'b1;
    @(negedge sys_clk);
    checkVal("ovfClear", bus.overflowH, 0);
    #1;
    bus.wr_enH   = 1'b1;
    bus.wr_dataH = 8'hEE;
    @(negedge sys_clk);
    checkVal("ovfSetWins", bus.overflowH, EXP_OVF);
    #1;
    bus.wr_enH   = 1'b0;
    bus.ovf_clrH = 1'b0;
    checkVal("ovfCountHold", bus.countH, 16);
    modelEn = 1'b1;
    waitRx("ovfRx", DEPTH, 1000);
    idle(3 * FRAME);
    checkVal("ovfPulses", rxQ.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) checkOutput("ovfOrder", i, 8'(8'h10 + i));

    // Push into full FIFO on the same edge as a pop
    modelEn    = 1'b0;
    manualDone = 1'b0;
    doReset();
    rxQ.delete();
    for (int i = 0; i < DEPTH; i++) pushByte(8'(8'h20 + i));
    checkVal("pfFull", bus.fullH, 1);
    bus.wr_enH   = 1'b1;
    bus.wr_dataH = 8'hEE;
    manualDone   = 1'b1;
    modelEn      = 1'b1;
    @(negedge sys_clk);
    checkVal("pfCount", bus.countH, 15);
    checkVal("pfNotFull", bus.fullH, 0);
    checkVal("pfXmit", bus.xmitH, 1);
    #1;
    bus.wr_enH = 1'b0;
    waitRx("pfRx", DEPTH, 1000);
    idle(3 * FRAME);
    checkVal("pfPulses", rxQ.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) checkOutput("pfOrder", i, 8'(8'h20 + i));

    // Twenty pushes across two bursts so both pointers wrap
    doReset();
    rxQ.delete();
    for (int i = 0; i < 12; i++) pushByte(8'(8'h40 + i));
    waitRx("wrapRxA", 12, 1000);
    for (int i = 12; i < 20; i++) pushByte(8'(8'h40 + i));
    waitRx("wrapRxB", 20, 1000);
    for (int i = 0; i < 20; i++) checkOutput("wrapOrder", i, 8'(8'h40 + i));

    // Reset while waiting for the stop bit with four bytes queued
    modelEn    = 1'b0;
    manualDone = 1'b1;
    doReset();
    for (int i = 0; i < 5; i++) pushByte(8'(8'h60 + i));
    checkVal("rmCount", bus.countH, 4);
    manualDone = 1'b0;
    idle(2);
    sys_rst_l = 1'b0;
    @(negedge sys_clk);
    checkVal("rmCount0", bus.countH, 0);
    checkVal("rmEmpty", bus.emptyH, 1);
    checkVal("rmFull", bus.fullH, 0);
    checkVal("rmXmit", bus.xmitH, 0);
    checkVal("rmData", bus.xmit_dataH, 8'h00);
    checkVal("rmOvf", bus.overflowH, 0);
    #1;
    sys_rst_l  = 1'b1;
    manualDone = 1'b1;
    rxQ.delete();
    idle(20);
    checkVal("rmNoPulse", rxQ.size(), 0);
    checkVal("rmStillEmpty", bus.emptyH, 1);
    modelEn = 1'b1;
    pushByte(8'h99);
    waitRx("rmRx", 1, 50);
    checkOutput("rmByte", 0, 8'h99);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
